// File: rtl/mem_pkg.sv
// Shared types and defaults for the dual-port clearable data memory.
package mem_pkg;

  typedef enum logic [0:0] {CLEAR, READY} mem_state_t;

  localparam int unsigned MEM_ADDR_W = 5;
  localparam int unsigned MEM_DATA_W = 4;

  // Even parity: the bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/mem_clr_seq.sv
// Clear sequencer: walks every address once after reset or on request,
// holding busy high until the last word has been written.
module mem_clr_seq
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  mem_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LastAddr) begin
          state_d = READY;
          done    = ~rst;
        end
      end
      READY: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign busy     = (state_q == CLEAR);
  // Reset must not disturb the array, so no clear write while rst is high.
  assign clr_we   = busy & ~rst;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/mem_dp_clr.sv
// Dual-read, single-write data memory with built-in clear sequencer and
// optional write-through bypass. Define MEM_DP_PARITY_EN for per-word parity.
module mem_dp_clr
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = MEM_ADDR_W,
  parameter int unsigned DATA_WIDTH  = MEM_DATA_W,
  parameter int unsigned CLEAR_VALUE = 0,
  parameter int unsigned BYPASS      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  output logic                  busy,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_err,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  perr_a,
  output logic                  perr_b,
  output logic                  perr_sticky
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] ClrData = DATA_WIDTH'(CLEAR_VALUE);
`ifdef MEM_DP_PARITY_EN
  localparam int unsigned WordW = DATA_WIDTH + 1;
`else
  localparam int unsigned WordW = DATA_WIDTH;
`endif

  function automatic logic [WordW-1:0] encode(input logic [DATA_WIDTH-1:0] d);
`ifdef MEM_DP_PARITY_EN
    return {even_parity(32'(d)), d};
`else
    return d;
`endif
  endfunction

  logic [WordW-1:0]      mem_q [DEPTH];
  logic                  clr_we, done, user_we, mem_we;
  logic [ADDR_WIDTH-1:0] clr_addr, mem_waddr;
  logic [WordW-1:0]      mem_wdata, word_a, word_b;
  logic                  byp_a, byp_b;
  logic                  wr_err_q, perr_sticky_q;

  mem_clr_seq #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .clear_req(clear_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .done     (done)
  );

  assign user_we = we & ~busy & ~rst;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = encode(wr_data);
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = encode(ClrData);
    end else if (user_we) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign word_a = mem_q[rd_addr_a];
  assign word_b = mem_q[rd_addr_b];
  assign byp_a  = (BYPASS != 0) && user_we && (rd_addr_a == wr_addr);
  assign byp_b  = (BYPASS != 0) && user_we && (rd_addr_b == wr_addr);

  // While clearing, the array is partly stale; present the clear value instead.
  assign rd_data_a = busy ? ClrData : (byp_a ? wr_data : word_a[DATA_WIDTH-1:0]);
  assign rd_data_b = busy ? ClrData : (byp_b ? wr_data : word_b[DATA_WIDTH-1:0]);

`ifdef MEM_DP_PARITY_EN
  assign perr_a = ~busy & ~byp_a &
                  (word_a[DATA_WIDTH] != even_parity(32'(word_a[DATA_WIDTH-1:0])));
  assign perr_b = ~busy & ~byp_b &
                  (word_b[DATA_WIDTH] != even_parity(32'(word_b[DATA_WIDTH-1:0])));
`else
  assign perr_a = 1'b0;
  assign perr_b = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_q      <= 1'b0;
      perr_sticky_q <= 1'b0;
    end else begin
      wr_err_q <= busy & we;
      if (done) begin
        perr_sticky_q <= 1'b0;
      end else if (perr_a | perr_b) begin
        perr_sticky_q <= 1'b1;
      end
    end
  end

  assign wr_err      = wr_err_q;
  assign perr_sticky = perr_sticky_q;

endmodule

// File: tb/tb_mem_dp_clr.sv
// Self-checking bench for mem_dp_clr: a default instance (BYPASS=1, clear 0)
// and a second one (BYPASS=0, CLEAR_VALUE=0x1A) driven by the same stimulus.
module tb_mem_dp_clr;

  localparam int unsigned DEPTH = 32;
  localparam logic [3:0]  NbClr = 4'hA;

  logic       clk = 1'b0;
  logic       rst, clear_req, we;
  logic [4:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [3:0] wr_data;

  logic       busy, wr_err, perr_a, perr_b, perr_sticky;
  logic [3:0] rd_data_a, rd_data_b;
  logic       nb_busy, nb_wr_err, nb_perr_a, nb_perr_b, nb_perr_sticky;
  logic [3:0] nb_rd_data_a, nb_rd_data_b;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] nba;
    logic [3:0] nbb;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic       err_q[$];
  logic [3:0] model[DEPTH];
  logic [3:0] model_nb[DEPTH];
  int         checks = 0;
  int         failures = 0;

  mem_dp_clr dut (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .busy       (busy),
    .we         (we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_err     (wr_err),
    .rd_addr_a  (rd_addr_a),
    .rd_data_a  (rd_data_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_b  (rd_data_b),
    .perr_a     (perr_a),
    .perr_b     (perr_b),
    .perr_sticky(perr_sticky)
  );

  mem_dp_clr #(
    .CLEAR_VALUE(32'h1A),
    .BYPASS     (0)
  ) dut_nb (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .busy       (nb_busy),
    .we         (we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_err     (nb_wr_err),
    .rd_addr_a  (rd_addr_a),
    .rd_data_a  (nb_rd_data_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_b  (nb_rd_data_b),
    .perr_a     (nb_perr_a),
    .perr_b     (nb_perr_b),
    .perr_sticky(nb_perr_sticky)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [4:0] addr, input logic [3:0] data);
    we = 1'b1; wr_addr = addr; wr_data = data;
    step();
    we = 1'b0;
    model[addr] = data;
    model_nb[addr] = data;
  endtask

  task automatic clear_models();
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = 4'h0;
      model_nb[i] = NbClr;
    end
  endtask

  task automatic test_reset();
    rd_exp_t e;
    rst = 1'b1; clear_req = 1'b0; we = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    step(); step();
    rst = 1'b0;
    for (int c = 0; c < DEPTH; c++) begin
      rd_addr_a = 5'($urandom_range(0, 31));
      rd_addr_b = 5'($urandom_range(0, 31));
      rd_q.push_back('{a: 4'h0, b: 4'h0, nba: NbClr, nbb: NbClr});
      #4;
      e = rd_q.pop_front();
      checks++;
      if ({busy, nb_busy, wr_err, perr_sticky} !== 4'b1100) begin
        failures++;
        $display("FAIL reset_flags c=%0d busy/nb_busy/wr_err/sticky=%b want 1100", c,
                 {busy, nb_busy, wr_err, perr_sticky});
      end
      checks++;
      if ({rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b, perr_a, perr_b} !== {e, 2'b00}) begin
        failures++;
        $display("FAIL reset_busy_read c=%0d got %h want %h", c,
                 {rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b, perr_a, perr_b}, {e, 2'b00});
      end
      step();
    end
    #4;
    checks++;
    if ({busy, nb_busy} !== 2'b00) begin
      failures++;
      $display("FAIL reset_busy_fall busy=%b%b want 00", busy, nb_busy);
    end
    step();
    clear_models();
    for (int i = 0; i < DEPTH / 2; i++) begin
      rd_addr_a = 5'(2 * i);
      rd_addr_b = 5'(2 * i + 1);
      rd_q.push_back('{a: model[2*i], b: model[2*i+1], nba: model_nb[2*i], nbb: model_nb[2*i+1]});
      #4;
      e = rd_q.pop_front();
      checks++;
      if ({rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b} !== e) begin
        failures++;
        $display("FAIL reset_cleared addr=%0d got %h want %h", 2 * i,
                 {rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b}, e);
      end
      step();
    end
  endtask

  task automatic test_write_read();
    rd_exp_t e;
    logic [4:0] pa[3];
    logic [4:0] pb[3];
    pa = '{5'd3, 5'd31, 5'd0};
    pb = '{5'd31, 5'd3, 5'd3};
    write_word(5'd3, 4'hA);
    write_word(5'd31, 4'h5);
    for (int i = 0; i < 3; i++) begin
      rd_addr_a = pa[i];
      rd_addr_b = pb[i];
      rd_q.push_back('{a: model[pa[i]], b: model[pb[i]], nba: model_nb[pa[i]],
                       nbb: model_nb[pb[i]]});
      #4;
      e = rd_q.pop_front();
      checks++;
      if ({rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b, perr_a, perr_b, wr_err}
          !== {e, 3'b000}) begin
        failures++;
        $display("FAIL write_read a=%0d b=%0d got %h want %h", pa[i], pb[i],
                 {rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b, perr_a, perr_b, wr_err},
                 {e, 3'b000});
      end
      step();
    end
  endtask

  task automatic test_bypass();
    rd_exp_t e;
    write_word(5'd7, 4'h1);
    we = 1'b1; wr_addr = 5'd7; wr_data = 4'hC; rd_addr_a = 5'd7; rd_addr_b = 5'd7;
    rd_q.push_back('{a: 4'hC, b: 4'hC, nba: model_nb[7], nbb: model_nb[7]});
    #4;
    e = rd_q.pop_front();
    checks++;
    if ({rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b, perr_a, perr_b} !== {e, 2'b00}) begin
      failures++;
      $display("FAIL bypass_same_cycle got %h want %h",
               {rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b, perr_a, perr_b}, {e, 2'b00});
    end
    step();
    model[7] = 4'hC; model_nb[7] = 4'hC;
    // Port A misses the write, port B hits it.
    wr_addr = 5'd8; wr_data = 4'h9; rd_addr_a = 5'd7; rd_addr_b = 5'd8;
    rd_q.push_back('{a: model[7], b: 4'h9, nba: model_nb[7], nbb: model_nb[8]});
    #4;
    e = rd_q.pop_front();
    checks++;
    if ({rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b} !== e) begin
      failures++;
      $display("FAIL bypass_split got %h want %h",
               {rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b}, e);
    end
    step();
    we = 1'b0;
    model[8] = 4'h9; model_nb[8] = 4'h9;
    rd_q.push_back('{a: model[7], b: model[8], nba: model_nb[7], nbb: model_nb[8]});
    #4;
    e = rd_q.pop_front();
    checks++;
    if ({rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b} !== e) begin
      failures++;
      $display("FAIL bypass_after_edge got %h want %h",
               {rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b}, e);
    end
    step();
  endtask

  task automatic test_clear_wr_err();
    rd_exp_t e;
    logic exp_err;
    write_word(5'd9, 4'hF);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    err_q.push_back(1'b0);
    for (int c = 0; c < DEPTH + 2; c++) begin
      we = (c == 2 || c == 5 || c == 6 || c == 31);
      wr_addr = 5'd2; wr_data = 4'h3;
      clear_req = (c == 10);
      rd_addr_a = 5'd9; rd_addr_b = 5'd2;
      err_q.push_back(we && (c < DEPTH));
      #4;
      exp_err = err_q.pop_front();
      checks++;
      if ({busy, wr_err, nb_wr_err} !== {c < DEPTH, exp_err, exp_err}) begin
        failures++;
        $display("FAIL clear_busy_wr_err c=%0d busy/wr_err/nb=%b want %b", c,
                 {busy, wr_err, nb_wr_err}, {c < DEPTH, exp_err, exp_err});
      end
      step();
    end
    we = 1'b0; clear_req = 1'b0;
    err_q.delete();
    clear_models();
    for (int i = 0; i < 2; i++) begin
      rd_addr_a = (i == 0) ? 5'd9 : 5'd3;
      rd_addr_b = (i == 0) ? 5'd2 : 5'd31;
      rd_q.push_back('{a: model[rd_addr_a], b: model[rd_addr_b], nba: model_nb[rd_addr_a],
                       nbb: model_nb[rd_addr_b]});
      #4;
      e = rd_q.pop_front();
      checks++;
      if ({rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b, wr_err} !== {e, 1'b0}) begin
        failures++;
        $display("FAIL clear_result i=%0d got %h want %h", i,
                 {rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b, wr_err}, {e, 1'b0});
      end
      step();
    end
  endtask

  task automatic test_reset_mid_clear();
    rd_exp_t e;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int c = 0; c < 10; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c <= DEPTH; c++) begin
      #4;
      checks++;
      if ({busy, nb_busy, wr_err} !== {c < DEPTH, c < DEPTH, 1'b0}) begin
        failures++;
        $display("FAIL midclear_busy c=%0d busy/nb/wr_err=%b want %b", c,
                 {busy, nb_busy, wr_err}, {c < DEPTH, c < DEPTH, 1'b0});
      end
      step();
    end
    clear_models();
    we = 1'b1; clear_req = 1'b1; wr_addr = 5'd12; wr_data = 4'h6;
    rd_addr_a = 5'd12; rd_addr_b = 5'd12;
    rd_q.push_back('{a: 4'h6, b: 4'h6, nba: model_nb[12], nbb: model_nb[12]});
    #4;
    e = rd_q.pop_front();
    checks++;
    if ({rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b, busy} !== {e, 1'b0}) begin
      failures++;
      $display("FAIL we_clear_same_cycle got %h want %h",
               {rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b, busy}, {e, 1'b0});
    end
    step();
    we = 1'b0; clear_req = 1'b0;
    #4;
    checks++;
    if ({busy, wr_err} !== 2'b10) begin
      failures++;
      $display("FAIL we_clear_busy_rise busy/wr_err=%b want 10", {busy, wr_err});
    end
    for (int c = 0; c < DEPTH; c++) step();
    rd_q.push_back('{a: model[12], b: model[12], nba: model_nb[12], nbb: model_nb[12]});
    #4;
    e = rd_q.pop_front();
    checks++;
    if ({rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b, busy} !== {e, 1'b0}) begin
      failures++;
      $display("FAIL we_clear_overwritten got %h want %h",
               {rd_data_a, rd_data_b, nb_rd_data_a, nb_rd_data_b, busy}, {e, 1'b0});
    end
    step();
  endtask

  task automatic test_parity();
    write_word(5'd4, 4'h6);
`ifdef MEM_DP_PARITY_EN
    dut.mem_q[4] = dut.mem_q[4] ^ 5'b00001;
    rd_addr_a = 5'd5; rd_addr_b = 5'd4;
    #4;
    checks++;
    if ({rd_data_b, perr_a, perr_b, perr_sticky, nb_perr_b} !== {4'h7, 4'b0100}) begin
      failures++;
      $display("FAIL parity_detect got %h want %h",
               {rd_data_b, perr_a, perr_b, perr_sticky, nb_perr_b}, {4'h7, 4'b0100});
    end
    step();
    rd_addr_b = 5'd5;
    #4;
    checks++;
    if ({perr_b, perr_sticky} !== 2'b01) begin
      failures++;
      $display("FAIL parity_sticky_set perr_b/sticky=%b want 01", {perr_b, perr_sticky});
    end
    step();
    #4;
    checks++;
    if (perr_sticky !== 1'b1) begin
      failures++;
      $display("FAIL parity_sticky_hold sticky=%b want 1", perr_sticky);
    end
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int c = 0; c < DEPTH; c++) step();
    #4;
    checks++;
    if ({busy, perr_sticky, perr_b} !== 3'b000) begin
      failures++;
      $display("FAIL parity_sticky_clear busy/sticky/perr_b=%b want 000",
               {busy, perr_sticky, perr_b});
    end
    step();
`else
    rd_addr_a = 5'd4; rd_addr_b = 5'd4;
    #4;
    checks++;
    if ({rd_data_a, perr_a, perr_b, perr_sticky} !== {4'h6, 3'b000}) begin
      failures++;
      $display("FAIL parity_off got %h want %h",
               {rd_data_a, perr_a, perr_b, perr_sticky}, {4'h6, 3'b000});
    end
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_clear_wr_err();
    test_reset_mid_clear();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
